arbiter21_leaf: RTL

//  Clocked 2:1 merge leaf for the tree network. It is the converging counterpart of the 1:2 leaf decoder.
//  Two 9-bit flit streams (In0, In1) are arbitrated round-robin onto one output stream.

---
 rtl/arbiter21_leaf.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/arbiter21_leaf.sv
// arbiter21_leaf: clocked 2:1 merge leaf for the tree network.
//
// Two W-bit flit streams are arbitrated round-robin onto one output stream
// through a 2-entry FIFO. Each output flit is tagged with its source
// (out_src: 0 = in0, 1 = in1) so the upstream decoder can steer replies.
//
// Optional feature macro: ARBITER21_TAIL_LOCK_EN
//   defined   : packet-level arbitration. A non-tail flit (data[W-1]=0)
//               locks the grant to its input until that input's tail flit.
//   undefined : flit-level round-robin. data[W-1] is ignored.
//
// Ports:
//   CLK, RESET            clock, asynchronous active-high reset
//   in0_data/valid/ready  input stream 0 (valid/ready handshake)
//   in1_data/valid/ready  input stream 1 (valid/ready handshake)
//   out_data/src/valid    head-of-FIFO flit, its source tag, FIFO non-empty
//   out_ready             sink takes the head flit when out_valid&out_ready
module arbiter21_leaf #(
  parameter int unsigned W     = 9,
  parameter int unsigned DEPTH = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [W-1:0] in0_data,
  input  logic         in0_valid,
  output logic         in0_ready,
  input  logic [W-1:0] in1_data,
  input  logic         in1_valid,
  output logic         in1_ready,
  output logic [W-1:0] out_data,
  output logic         out_src,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [1:0] Full = 2'(DEPTH);

  // FIFO storage: each entry is {src, data}
  logic [W:0] mem_q [2];
  logic [1:0] count_q, count_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       prio_q, prio_d;

  logic       lock;
  logic       lock_src;

  logic       space;
  logic       grant0, grant1;
  logic       push0, push1, push, pop;
  logic       push_src;
  logic [W-1:0] push_data;
  logic [W:0] head;

  assign space = (count_q != Full);

  // Grant: locked input owns the output; otherwise prio breaks ties only
  // when both inputs are valid. Neither ready looks at its own valid.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (lock) begin
      grant0 = space & ~lock_src;
      grant1 = space &  lock_src;
    end else begin
      grant0 = space & (~prio_q | ~in1_valid);
      grant1 = space & ( prio_q | ~in0_valid);
    end
  end

  assign in0_ready = grant0 & ~RESET;
  assign in1_ready = grant1 & ~RESET;

  // Both grants can be high only when at most one input is valid, so at
  // most one push per cycle; the ~push0 term just makes that explicit.
  assign push0     = in0_valid & in0_ready;
  assign push1     = in1_valid & in1_ready & ~push0;
  assign push      = push0 | push1;
  assign push_src  = push1;
  assign push_data = push1 ? in1_data : in0_data;

  assign pop = out_valid & out_ready;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    prio_d   = prio_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    if (push) begin
      wr_ptr_d = ~wr_ptr_q;
      prio_d   = ~push_src;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      prio_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      prio_q   <= prio_d;
    end
  end

  // Entries are cleared on reset so out_data/out_src read 0 afterwards.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else if (push) begin
      mem_q[wr_ptr_q] <= {push_src, push_data};
    end
  end

`ifdef ARBITER21_TAIL_LOCK_EN
  logic lock_q, lock_d;
  logic lock_src_q, lock_src_d;

  always_comb begin
    lock_d     = lock_q;
    lock_src_d = lock_src_q;
    if (push) begin
      if (push_data[W-1]) begin
        lock_d = 1'b0;
      end else begin
        lock_d     = 1'b1;
        lock_src_d = push_src;
      end
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_q     <= 1'b0;
      lock_src_q <= 1'b0;
    end else begin
      lock_q     <= lock_d;
      lock_src_q <= lock_src_d;
    end
  end

  assign lock     = lock_q;
  assign lock_src = lock_src_q;
`else
  assign lock     = 1'b0;
  assign lock_src = 1'b0;
`endif

  assign head      = mem_q[rd_ptr_q];
  assign out_data  = head[W-1:0];
  assign out_src   = head[W];
  assign out_valid = (count_q != 2'd0);

endmodule
